// File: rtl/switch_debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module      : switch_debounce_pkg
// Description : Shared constants and width helper for the switch debouncer.
// Revision    : 1.0 - initial release
// ============================================================================
package switch_debounce_pkg;

    localparam int unsigned c_sys_clk_freq          = 30_000_000;
    // One debounce tick per millisecond of system clock.
    localparam int unsigned c_debounce_tick_cycles  = c_sys_clk_freq / 1000;
    localparam int unsigned c_debounce_stable_ticks = 10;
    localparam int unsigned c_sw_debounce_width     = 16;

    // Bits needed to hold 0..max_val; never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/switch_debounce_chan.sv
`default_nettype none
// ============================================================================
// Module      : switch_debounce_chan
// Description : One debounce channel: stability counter, level and edge flops.
// Revision    : 1.0 - initial release
// ============================================================================
module switch_debounce_chan #(
    parameter int unsigned STABLE_TICKS = 10,
    parameter int unsigned CNT_W        = 4,
    parameter logic        RESET_VALUE  = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sync_i,
    input  logic tick_i,
    input  logic bypass_i,
    output logic stable_o,
    output logic rise_o,
    output logic fall_o,
    output logic edge_nxt_o
);

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(STABLE_TICKS - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_stable;
    logic             w_stable_nxt;
    logic             r_rise;
    logic             r_fall;
    logic             w_rise_nxt;
    logic             w_fall_nxt;

    // Any cycle of agreement clears the count, so short glitches never accumulate.
    always_comb begin
        w_cnt_nxt    = r_cnt;
        w_stable_nxt = r_stable;
        if (bypass_i) begin
            w_cnt_nxt    = '0;
            w_stable_nxt = sync_i;
        end else if (sync_i == r_stable) begin
            w_cnt_nxt = '0;
        end else if (tick_i) begin
            if (r_cnt == c_cnt_last) begin
                w_stable_nxt = sync_i;
                w_cnt_nxt    = '0;
            end else begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
            end
        end
    end

    assign w_rise_nxt = w_stable_nxt & ~r_stable;
    assign w_fall_nxt = ~w_stable_nxt & r_stable;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt    <= '0;
            r_stable <= RESET_VALUE;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_stable <= w_stable_nxt;
            r_rise   <= w_rise_nxt;
            r_fall   <= w_fall_nxt;
        end
    end

    assign stable_o   = r_stable;
    assign rise_o     = r_rise;
    assign fall_o     = r_fall;
    assign edge_nxt_o = w_rise_nxt | w_fall_nxt;

endmodule
`default_nettype wire

// File: rtl/switch_debounce.sv
`default_nettype none
// ============================================================================
// Module      : switch_debounce
// Description : Synchronises and debounces switch inputs with edge pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module switch_debounce
    import switch_debounce_pkg::*;
#(
    parameter int unsigned      WIDTH        = c_sw_debounce_width,
    parameter int unsigned      TICK_CYCLES  = c_debounce_tick_cycles,
    parameter int unsigned      STABLE_TICKS = c_debounce_stable_ticks,
    parameter logic [WIDTH-1:0] RESET_VALUE  = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] sw_i,
    input  logic             bypass_i,
    output logic [WIDTH-1:0] stable_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    output logic             event_o
);

    localparam int unsigned              c_cnt_w      = cnt_width(STABLE_TICKS);
    localparam int unsigned              c_presc_w    = cnt_width(TICK_CYCLES - 1);
    localparam logic [c_presc_w-1:0]     c_presc_last = c_presc_w'(TICK_CYCLES - 1);

    if (TICK_CYCLES == 0) begin : g_bad_tick_cycles
        $error("switch_debounce: TICK_CYCLES must be at least 1");
    end
    if ((STABLE_TICKS == 0) || (STABLE_TICKS > 255)) begin : g_bad_stable_ticks
        $error("switch_debounce: STABLE_TICKS must be within 1..255");
    end

    logic [WIDTH-1:0]     r_sync_q1;
    logic [WIDTH-1:0]     r_sync;
    logic [c_presc_w-1:0] r_presc;
    logic                 w_tick;
    logic [WIDTH-1:0]     w_edge_nxt;
    logic                 r_event;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync_q1 <= RESET_VALUE;
            r_sync    <= RESET_VALUE;
        end else begin
            r_sync_q1 <= sw_i;
            r_sync    <= r_sync_q1;
        end
    end

    // With a single-cycle tick period the counter stays at 0 and ticks every cycle.
    assign w_tick = (r_presc == c_presc_last);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + c_presc_w'(1);
        end
    end

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
        switch_debounce_chan #(
            .STABLE_TICKS (STABLE_TICKS),
            .CNT_W        (c_cnt_w),
            .RESET_VALUE  (RESET_VALUE[gi])
        ) u_chan (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .sync_i     (r_sync[gi]),
            .tick_i     (w_tick),
            .bypass_i   (bypass_i),
            .stable_o   (stable_o[gi]),
            .rise_o     (rise_o[gi]),
            .fall_o     (fall_o[gi]),
            .edge_nxt_o (w_edge_nxt[gi])
        );
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_event <= 1'b0;
        end else begin
            r_event <= |w_edge_nxt;
        end
    end

    assign event_o = r_event;

endmodule
`default_nettype wire
